// File: rtl/adc_stream_packer.sv
// adc_stream_packer: captures ADC samples into a small FIFO and serializes one
// acquisition frame as a byte stream (header, then high/low byte per sample).
module adc_stream_packer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [11:0]       n_samples,
  input  logic [1:0]        ch_sel,
  input  logic [11:0]       adc_data,
  input  logic              adc_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   fill
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HI   = 3'd3;
  localparam logic [2:0] ST_LO   = 3'd4;

  logic [2:0]       state, stateNext;
  logic [11:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr, wrPtrNext, rdPtrNext;
  logic             adcReadyQ;
  logic [11:0]      nReg, nRegNext;
  logic [1:0]       chReg, chRegNext;
  logic [11:0]      capCnt, capCntNext;
  logic [11:0]      txCnt, txCntNext;
  logic [7:0]       lowByte, lowByteNext;
  logic [7:0]       txDataNext;
  logic             txValidNext, busyNext, doneNext, overflowNext;
  logic             push, pop, sampleEvt, handshake;
  logic [11:0]      rdWord;

  assign rdWord    = mem[rdPtr[ADDR_W-1:0]];
  assign sampleEvt = adc_ready && !adcReadyQ;
  assign handshake = tx_valid && tx_ready;

  // Next-state, output and capture decisions
  always_comb begin
    stateNext    = state;
    txDataNext   = tx_data;
    txValidNext  = tx_valid;
    busyNext     = busy;
    doneNext     = 1'b0;
    overflowNext = overflow;
    nRegNext     = nReg;
    chRegNext    = chReg;
    capCntNext   = capCnt;
    txCntNext    = txCnt;
    lowByteNext  = lowByte;
    push         = 1'b0;
    pop          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (arm && (n_samples != 12'd0)) begin
          nRegNext     = n_samples;
          chRegNext    = ch_sel;
          capCntNext   = 12'd0;
          txCntNext    = 12'd0;
          overflowNext = 1'b0;
          busyNext     = 1'b1;
          txDataNext   = HEADER;
          txValidNext  = 1'b1;
          stateNext    = ST_HDR;
        end
      end
      ST_HDR: begin
        if (handshake) begin
          txValidNext = 1'b0;
          stateNext   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (txCnt == nReg) begin
          busyNext  = 1'b0;
          doneNext  = 1'b1;
          stateNext = ST_IDLE;
        end else if (fill != PTR_W'(0)) begin
          pop         = 1'b1;
          txDataNext  = {chReg, 2'b00, rdWord[11:8]};
          lowByteNext = rdWord[7:0];
          txValidNext = 1'b1;
          stateNext   = ST_HI;
        end
      end
      ST_HI: begin
        if (handshake) begin
          txDataNext = lowByte;
          stateNext  = ST_LO;
        end
      end
      ST_LO: begin
        if (handshake) begin
          txCntNext   = txCnt + 12'd1;
          txValidNext = 1'b0;
          stateNext   = ST_WAIT;
        end
      end
      default: stateNext = ST_IDLE;
    endcase

    // Capture window: only while a frame is active and samples are still owed
    if (sampleEvt && busy && (capCnt < nReg)) begin
      if (fill != PTR_W'(FIFO_DEPTH)) begin
        push       = 1'b1;
        capCntNext = capCnt + 12'd1;
      end else begin
        overflowNext = 1'b1;
      end
    end

    wrPtrNext = wrPtr + PTR_W'(push);
    rdPtrNext = rdPtr + PTR_W'(pop);
  end

  // State, control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wrPtr     <= '0;
      rdPtr     <= '0;
      fill      <= '0;
      adcReadyQ <= 1'b0;
      nReg      <= 12'd0;
      chReg     <= 2'b00;
      capCnt    <= 12'd0;
      txCnt     <= 12'd0;
      lowByte   <= 8'd0;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= stateNext;
      wrPtr     <= wrPtrNext;
      rdPtr     <= rdPtrNext;
      fill      <= wrPtrNext - rdPtrNext;
      adcReadyQ <= adc_ready;
      nReg      <= nRegNext;
      chReg     <= chRegNext;
      capCnt    <= capCntNext;
      txCnt     <= txCntNext;
      lowByte   <= lowByteNext;
      tx_data   <= txDataNext;
      tx_valid  <= txValidNext;
      busy      <= busyNext;
      done      <= doneNext;
      overflow  <= overflowNext;
    end
  end

  // Sample storage, written on the same edge the capture is accepted
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr[ADDR_W-1:0]] <= adc_data;
    end
  end

endmodule

// File: tb/tb_adc_stream_packer.sv
// Testbench for adc_stream_packer: directed scenarios plus randomized frames
// checked against a frame model built from sample lists.
module tb_adc_stream_packer;

  logic        clk;
  logic        rst;
  logic        arm;
  logic [11:0] n_samples;
  logic [1:0]  ch_sel;
  logic [11:0] adc_data;
  logic        adc_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [4:0]  fill;

  int checks = 0;
  int failures = 0;
  int doneCnt = 0;
  int readyMode = 0;      // 0 low, 1 high, 2 random, 3 toggle, 4 manual
  logic manualReady = 1'b0;
  logic [7:0]  got[$];
  logic [11:0] samples[$];

  adc_stream_packer #(.FIFO_DEPTH(16), .ADDR_W(4), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .arm(arm), .n_samples(n_samples), .ch_sel(ch_sel),
    .adc_data(adc_data), .adc_ready(adc_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done),
    .overflow(overflow), .fill(fill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Host-side ready driver
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0: tx_ready = 1'b0;
        1: tx_ready = 1'b1;
        2: tx_ready = 1'($urandom_range(0, 1));
        3: tx_ready = ~tx_ready;
        default: tx_ready = manualReady;
      endcase
    end
  end

  // Byte collector, done counter and stall-stability checker
  initial begin
    logic prevStall;
    logic [7:0] prevData;
    prevStall = 1'b0;
    prevData = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          chk("stall_valid", 32'(tx_valid), 32'd1);
          chk("stall_data", 32'(tx_data), 32'(prevData));
        end
        if (tx_valid && tx_ready) got.push_back(tx_data);
        if (done) doneCnt++;
        prevStall = tx_valid && !tx_ready;
        prevData = tx_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [11:0] n, input logic [1:0] c);
    arm = 1'b1;
    n_samples = n;
    ch_sel = c;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse(input logic [11:0] d, input int width, input int gap);
    adc_data = d;
    adc_ready = 1'b1;
    repeat (width) tick();
    adc_ready = 1'b0;
    tick();
    repeat (gap) tick();
  endtask

  task automatic wait_done(input string tag, input int startDone);
    int i;
    i = 0;
    while (doneCnt == startDone && i < 2000) begin
      tick();
      i++;
    end
    repeat (3) tick();
    chk({tag, "_done_count"}, 32'(doneCnt - startDone), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  // Expected frame: header, then {ch,00,s[11:8]} and s[7:0] per sample
  task automatic check_frame(input string tag, input logic [1:0] c);
    logic [7:0] exp[$];
    logic [11:0] s;
    exp.push_back(8'hA5);
    foreach (samples[i]) begin
      s = samples[i];
      exp.push_back({c, 2'b00, s[11:8]});
      exp.push_back(s[7:0]);
    end
    chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    int start;
    int n;
    logic [1:0] c;
    logic [11:0] s;

    rst = 1'b1;
    arm = 1'b0;
    n_samples = 12'd0;
    ch_sel = 2'b00;
    adc_data = 12'd0;
    adc_ready = 1'b0;
    repeat (3) tick();
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic frame
    readyMode = 1;
    got.delete(); samples.delete();
    samples.push_back(12'hABC); samples.push_back(12'h123);
    start = doneCnt;
    do_arm(12'd2, 2'b01);
    pulse(12'hABC, 1, 2);
    pulse(12'h123, 1, 2);
    wait_done("basic", start);
    check_frame("basic", 2'b01);

    // Backpressure with toggling ready
    readyMode = 3;
    got.delete(); samples.delete();
    samples.push_back(12'hFFF);
    start = doneCnt;
    do_arm(12'd1, 2'b10);
    pulse(12'hFFF, 1, 1);
    wait_done("bp", start);
    check_frame("bp", 2'b10);

    // Overflow: 17 events into a 16-deep FIFO with the link stalled
    readyMode = 0;
    repeat (2) tick();
    got.delete(); samples.delete();
    start = doneCnt;
    do_arm(12'd20, 2'b01);
    for (int k = 0; k < 17; k++) begin
      s = 12'($urandom_range(0, 4095));
      if (k < 16) samples.push_back(s);
      pulse(s, 1, 0);
    end
    chk("ovf_fill", 32'(fill), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    readyMode = 1;
    repeat (10) tick();
    for (int k = 0; k < 4; k++) begin
      s = 12'($urandom_range(0, 4095));
      samples.push_back(s);
      pulse(s, 1, 4);
    end
    wait_done("ovf", start);
    check_frame("ovf", 2'b01);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Level-held ready and out-of-window events
    got.delete(); samples.delete();
    readyMode = 0;
    pulse(12'h555, 1, 1);
    chk("idle_evt_fill", 32'(fill), 32'd0);
    start = doneCnt;
    do_arm(12'd3, 2'b01);
    chk("arm_clears_ovf", 32'(overflow), 32'd0);
    samples.push_back(12'h9A1);
    pulse(12'h9A1, 10, 1);
    chk("level_fill", 32'(fill), 32'd1);
    samples.push_back(12'h0F0); samples.push_back(12'h70E);
    pulse(12'h0F0, 1, 1);
    pulse(12'h70E, 2, 1);
    chk("win_fill3", 32'(fill), 32'd3);
    pulse(12'h333, 1, 1);
    chk("outwin_fill", 32'(fill), 32'd3);
    readyMode = 1;
    wait_done("level", start);
    check_frame("level", 2'b01);

    // Ignored arms
    got.delete(); samples.delete();
    do_arm(12'd0, 2'b01);
    repeat (3) tick();
    chk("arm0_busy", 32'(busy), 32'd0);
    chk("arm0_valid", 32'(tx_valid), 32'd0);
    chk("arm0_bytes", 32'(got.size()), 32'd0);
    start = doneCnt;
    do_arm(12'd2, 2'b01);
    tick();
    do_arm(12'd5, 2'b10);
    samples.push_back(12'h4D2); samples.push_back(12'hE07);
    pulse(12'h4D2, 1, 2);
    pulse(12'hE07, 1, 2);
    wait_done("rearm", start);
    check_frame("rearm", 2'b01);

    // Reset during an HI stall
    got.delete(); samples.delete();
    readyMode = 0;
    tick();
    do_arm(12'd1, 2'b01);
    pulse(12'hC3C, 1, 0);
    readyMode = 4;
    manualReady = 1'b1;
    tick();
    manualReady = 1'b0;
    repeat (2) tick();
    chk("hi_stall_valid", 32'(tx_valid), 32'd1);
    chk("hi_stall_data", 32'(tx_data), 32'h4C);
    start = doneCnt;
    rst = 1'b1;
    #1;
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    chk("arst_tx_valid", 32'(tx_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_fill", 32'(fill), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("arst_no_done", 32'(doneCnt - start), 32'd0);
    got.delete(); samples.delete();
    readyMode = 1;
    start = doneCnt;
    do_arm(12'd1, 2'b10);
    samples.push_back(12'h2B7);
    pulse(12'h2B7, 1, 1);
    wait_done("post_rst", start);
    check_frame("post_rst", 2'b10);

    // Randomized frames with random backpressure
    for (int it = 0; it < 6; it++) begin
      got.delete(); samples.delete();
      readyMode = 2;
      n = $urandom_range(1, 10);
      c = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      start = doneCnt;
      do_arm(12'(n), c);
      for (int k = 0; k < n; k++) begin
        s = 12'($urandom_range(0, 4095));
        samples.push_back(s);
        pulse(s, $urandom_range(1, 3), $urandom_range(0, 4));
      end
      wait_done($sformatf("rnd%0d", it), start);
      check_frame($sformatf("rnd%0d", it), c);
      chk($sformatf("rnd%0d_ovf", it), 32'(overflow), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_stream_packer.md
Name: adc_stream_packer

Overview:
Downstream consumer of the ADC acquisition path. Captures each 12-bit sample announced by the ADC ready signal into a small FIFO, then serializes one acquisition frame as a byte stream for the host link: one header byte, then two bytes per sample, high byte first. The frame is armed by the same command that starts the ADC acquisition. The frame ends after a programmed number of samples has been transmitted.

Parameters:
FIFO_DEPTH, 16, sample FIFO depth in 12-bit words; must be a power of 2.
ADDR_W, 4, log2(FIFO_DEPTH).
HEADER, 8'hA5, frame start byte.

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
arm  in  1  one-cycle start pulse; captures n_samples and ch_sel
n_samples  in  12  number of samples in the frame
ch_sel  in  2  ADC channel tag (01 = ADC1, 10 = ADC2)
adc_data  in  12  sample word from the ADC controller
adc_ready  in  1  ADC ready; a new sample is the 0->1 transition
tx_data  out  8  byte to the host link
tx_valid  out  1  tx_data is valid
tx_ready  in  1  host link accepts the byte
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last byte is accepted
overflow  out  1  sticky: a sample was dropped because the FIFO was full
fill  out  ADDR_W+1  current FIFO occupancy

Behaviour:
Reset (async, rst=1)
- tx_data=0, tx_valid=0, busy=0, done=0, overflow=0, fill=0.
- FIFO pointers, counters and adc_ready_q are cleared; state=IDLE.
- Reset asserted mid-frame aborts the frame. No done pulse is produced and no further bytes are sent.

Edge detect
- adc_ready_q is adc_ready registered.
- A sample event is adc_ready=1 && adc_ready_q=0. A held-high adc_ready yields exactly one event.

Capture
- Enabled only while busy=1 and cap_cnt < n_reg.
- On a sample event with the FIFO not full, adc_data is written at that same clock edge and cap_cnt increments.
- On a sample event with the FIFO full, the sample is dropped, overflow is set, and cap_cnt does not increment.
- Events outside the capture window are ignored.

FIFO
- Single clock. A simultaneous write and read in one cycle is legal at any fill level, except that a write is refused when fill==FIFO_DEPTH before the read.
- fill = wr_ptr - rd_ptr, using ADDR_W+1-bit pointers so that full and empty are unambiguous.

FSM
- IDLE: on arm with n_samples != 0, latch n_reg and ch_reg, clear cap_cnt, tx_cnt and overflow, set busy=1, and go to HDR.
  - arm with n_samples == 0 is ignored.
  - arm while busy=1 is ignored (all states other than IDLE).
- HDR: tx_data=HEADER, tx_valid=1. On tx_valid && tx_ready, go to WAIT.
- WAIT: tx_valid=0.
  - If tx_cnt == n_reg: go to IDLE, busy=0, and pulse done for 1 cycle on that transition.
  - Else if the FIFO is not empty: pop one word, load tx_data={ch_reg, 2'b00, word[11:8]}, and go to HI.
- HI: tx_valid=1. On handshake, load tx_data=word[7:0] and go to LO.
- LO: tx_valid=1. On handshake, tx_cnt increments and the FSM goes to WAIT.

Handshake rules
- tx_data is registered and stays stable while tx_valid && !tx_ready.
- tx_valid never drops without a handshake.

Latency
- A sample written at edge k, with the FSM in WAIT and the FIFO previously empty, is popped at edge k+1. The HI byte is valid from k+1.
- done rises one edge after the final LO handshake (via WAIT).

Frame size
- A frame of n samples is exactly 1 + 2n bytes.
- tx_cnt and cap_cnt are 12 bits. n_samples=4095 is the maximum; there is no wrap.

Test Plan:
- Basic frame: arm with n=2, ch_sel=01; adc_data 12'hABC then 12'h123, each as one adc_ready pulse; tx_ready=1 -> bytes A5, 4A, BC, 41, 23. done pulses once, then busy=0.
- Backpressure: n=1, ch=10, sample 12'hFFF, with tx_ready toggling 0/1 every cycle -> bytes A5, 8F, FF. tx_data is held stable across stall cycles and there are no duplicate bytes.
- Overflow: n=20, tx_ready=0, 17 sample events with FIFO_DEPTH=16 -> fill=16, overflow=1. Then tx_ready=1 and 4 more events -> 20 samples total sent (16 held plus 4 new), done pulses, and overflow stays 1 until the next arm.
- Level ready / out-of-window events: adc_ready held high for 10 cycles counts as 1 sample. Events while IDLE, or after cap_cnt reaches n, leave fill unchanged.
- Ignored arms: arm with n=0 -> busy stays 0 and no bytes are sent. A second arm mid-frame does not change n_reg or ch_reg.
- Reset mid-frame: assert rst during an HI stall -> all outputs are 0 immediately (asynchronously). After rst deasserts, a new arm with n=1 produces a clean 3-byte frame.
